node_pool_allocator: RTL

- Manages the free-node pool of the linked-list engine.
- Holds a free bitmap (1 = free) and hands out the lowest-index free node.
- Round-robins between two allocation requesters (insert path and copy/splice path) and accepts node returns from the delete path.
- After reset or flush, sweeps the external next-pointer RAM, writing a null pointer into every node slot before accepting traffic.

---
 rtl/node_pool_allocator_if.sv | 38 +++
 rtl/node_pool_allocator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/node_pool_allocator_if.sv
// Allocation / free handshake bundle between the linked-list engine and the
// node pool allocator.
//   req_i        : level allocation requests, bit k = requester k (0 insert, 1 copy/splice)
//   gnt_o        : one-hot single-cycle grant pulse
//   alloc_addr_o : node handed out, valid while gnt_o != 0
//   free_valid_i : node return strobe from the delete path
//   free_addr_i  : node being returned
//   err_o        : single-cycle pulse on an illegal free
interface node_pool_allocator_if #(
    parameter int ADDR_W = 4
);
    logic [1:0]        req_i;
    logic [1:0]        gnt_o;
    logic [ADDR_W-1:0] alloc_addr_o;
    logic              free_valid_i;
    logic [ADDR_W-1:0] free_addr_i;
    logic              err_o;

    // Engine side: raises requests and returns nodes.
    modport master (
        output req_i,
        output free_valid_i,
        output free_addr_i,
        input  gnt_o,
        input  alloc_addr_o,
        input  err_o
    );

    // Allocator side.
    modport slave (
        input  req_i,
        input  free_valid_i,
        input  free_addr_i,
        output gnt_o,
        output alloc_addr_o,
        output err_o
    );
endinterface

// File: rtl/node_pool_allocator.sv
// Free-node pool for the linked-list engine.
// Keeps a free bitmap (1 = free), hands out the lowest-index free node to one
// of two round-robin requesters, takes node returns from the delete path, and
// after reset/flush sweeps the next-pointer RAM writing null into every slot.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : return all nodes and re-run the init sweep
//   bus          : request/grant/free handshake (slave side)
//   init_we_o    : next-pointer RAM write enable during the sweep
//   init_addr_o  : sweep write address (write data is null, supplied externally)
//   ready_o      : pool is in RUN
//   free_cnt_o   : number of free nodes
//   empty_o      : no free nodes
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_INIT | sweeping next-pointer RAM, no grants, frees flagged as errors
// S_RUN  | arbitrating requests and accepting node returns
module node_pool_allocator #(
    parameter int NUM_NODES = 16,
    parameter int ADDR_W    = $clog2(NUM_NODES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    node_pool_allocator_if.slave  bus,
    output logic                  init_we_o,
    output logic [ADDR_W-1:0]     init_addr_o,
    output logic                  ready_o,
    output logic [ADDR_W:0]       free_cnt_o,
    output logic                  empty_o
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NODES - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(NUM_NODES);

    state_t                 state_q,      state_d;
    logic [NUM_NODES-1:0]   bitmap_q,     bitmap_d;
    logic [ADDR_W:0]        cnt_q,        cnt_d;
    logic                   rr_q,         rr_d;
    logic [1:0]             gnt_q,        gnt_d;
    logic [ADDR_W-1:0]      alloc_addr_q, alloc_addr_d;
    logic                   err_q,        err_d;
    logic [ADDR_W-1:0]      init_addr_q,  init_addr_d;
    logic                   init_we_q,    init_we_d;
    logic                   ready_q,      ready_d;

    logic [ADDR_W-1:0]      low_idx;
    logic                   win;
    logic                   do_grant;
    logic                   do_free;

    // Lowest set bit of the registered bitmap; scanning downward lets the
    // last hit (lowest index) win.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (bitmap_q[i]) begin
                low_idx = ADDR_W'(i);
            end
        end
    end

    // With both requesting, rr picks; otherwise the lone requester wins.
    assign win      = (bus.req_i == 2'b11) ? rr_q : bus.req_i[1];
    assign do_grant = (state_q == S_RUN) && (bus.req_i != 2'b00) && (bitmap_q != '0);
    // A node returned while still marked free is illegal. A grant and a legal
    // free in the same cycle can never collide: the granted bit is set, so a
    // free of that address is itself illegal.
    assign do_free  = (state_q == S_RUN) && bus.free_valid_i && !bitmap_q[bus.free_addr_i];

    always_comb begin
        state_d      = state_q;
        bitmap_d     = bitmap_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        gnt_d        = 2'b00;
        alloc_addr_d = alloc_addr_q;
        err_d        = 1'b0;
        init_addr_d  = init_addr_q;
        init_we_d    = init_we_q;
        ready_d      = ready_q;

        if (flush_i) begin
            state_d      = S_INIT;
            bitmap_d     = '1;
            cnt_d        = FULL_CNT;
            rr_d         = 1'b0;
            alloc_addr_d = '0;
            init_addr_d  = '0;
            init_we_d    = 1'b1;
            ready_d      = 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    init_we_d = 1'b1;
                    err_d     = bus.free_valid_i;
                    if (init_addr_q == LAST_ADDR) begin
                        state_d     = S_RUN;
                        ready_d     = 1'b1;
                        init_we_d   = 1'b0;
                        init_addr_d = '0;
                    end else begin
                        init_addr_d = init_addr_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (do_grant) begin
                        gnt_d[win]        = 1'b1;
                        alloc_addr_d      = low_idx;
                        bitmap_d[low_idx] = 1'b0;
                        rr_d              = ~win;
                    end
                    if (do_free) begin
                        bitmap_d[bus.free_addr_i] = 1'b1;
                    end
                    err_d = bus.free_valid_i && !do_free;
                    cnt_d = cnt_q - (ADDR_W + 1)'(do_grant) + (ADDR_W + 1)'(do_free);
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            bitmap_q     <= '1;
            cnt_q        <= FULL_CNT;
            rr_q         <= 1'b0;
            gnt_q        <= 2'b00;
            alloc_addr_q <= '0;
            err_q        <= 1'b0;
            init_addr_q  <= '0;
            init_we_q    <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitmap_q     <= bitmap_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            alloc_addr_q <= alloc_addr_d;
            err_q        <= err_d;
            init_addr_q  <= init_addr_d;
            init_we_q    <= init_we_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.alloc_addr_o = alloc_addr_q;
    assign bus.err_o        = err_q;
    assign init_we_o        = init_we_q;
    assign init_addr_o      = init_addr_q;
    assign ready_o          = ready_q;
    assign free_cnt_o       = cnt_q;
    assign empty_o          = (cnt_q == '0);

endmodule
